// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative, write-back, write-allocate data cache
// between the CPU load/store path and a BurstRAM. A miss moves a full line
// as one burst. Victims are chosen by per-way age counters (0 = MRU).
// Build macro CACHE_STATS_EN adds internal saturating counters
// stat_cache_hits, stat_cache_misses and stat_writebacks (ports unchanged).
//
// state  | meaning
// INIT   | clearing valid/dirty/age of one set per cycle
// IDLE   | ready for a request
// LOOKUP | parallel tag compare; hit completes, miss picks a victim
// WB     | streaming a dirty victim line back as one write burst
// FILL   | reading the requested line as one read burst
module cache_assoc #(
  parameter int ADDRESS_BITWIDTH        = 32,
  parameter int DATA_BITWIDTH           = 32,
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int LINE_IX_BITWIDTH        = 1,
  parameter int WAYS_BITWIDTH           = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [ADDRESS_BITWIDTH-1:0]          address,
  input  logic [DATA_BITWIDTH-1:0]             data_in,
  input  logic [DATA_BITWIDTH/8-1:0]           write_enable_bytes,
  output logic [DATA_BITWIDTH-1:0]             data_out,
  output logic                                 data_out_valid,
  output logic                                 busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int BYTES         = DATA_BITWIDTH / 8;
  localparam int LINE_BITS     = RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH;
  localparam int OFFSET_BITS   = $clog2(LINE_BITS / 8);
  localparam int BYTE_OFF_BITS = $clog2(BYTES);
  localparam int WORDS         = LINE_BITS / DATA_BITWIDTH;
  localparam int WORD_IX_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NUM_SETS      = 1 << LINE_IX_BITWIDTH;
  localparam int SET_BITS      = (LINE_IX_BITWIDTH > 0) ? LINE_IX_BITWIDTH : 1;
  localparam int TAG_BITS      = ADDRESS_BITWIDTH - OFFSET_BITS - LINE_IX_BITWIDTH;
  localparam int WAYS          = 1 << WAYS_BITWIDTH;
  localparam int WAY_BITS      = (WAYS_BITWIDTH > 0) ? WAYS_BITWIDTH : 1;
  localparam int BEAT_BITS     = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FILL} state_t;

  state_t                      state;
  logic [ADDRESS_BITWIDTH-1:0] req_addr;
  logic [DATA_BITWIDTH-1:0]    req_data;
  logic [BYTES-1:0]            req_be;
  logic                        first_lookup;
  logic                        cmd_sent;
  logic [WAY_BITS-1:0]         victim_q;
  logic [BEAT_BITS-1:0]        beat;
  logic [SET_BITS-1:0]         init_set;

  logic [LINE_BITS-1:0] line_q  [NUM_SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][WAYS];
  logic                 valid_q [NUM_SETS][WAYS];
  logic                 dirty_q [NUM_SETS][WAYS];
  logic [WAY_BITS-1:0]  age_q   [NUM_SETS][WAYS];

`ifdef CACHE_STATS_EN
  logic [31:0] stat_cache_hits;
  logic [31:0] stat_cache_misses;
  logic [31:0] stat_writebacks;
`endif

  logic [SET_BITS-1:0]                req_set;
  logic [TAG_BITS-1:0]                req_tag;
  logic [WORD_IX_BITS-1:0]            word_ix;
  logic                               hit;
  logic [WAY_BITS-1:0]                hit_way;
  logic [WAY_BITS-1:0]                victim_way;
  logic                               victim_dirty;
  logic [LINE_BITS-1:0]               hit_line;
  logic [LINE_BITS-1:0]               merged_line;
  logic [DATA_BITWIDTH-1:0]           hit_word;
  logic [WAY_BITS-1:0]                touch_way;
  logic [WAY_BITS-1:0]                new_age [WAYS];
  logic [RAM_BURST_DATA_BITWIDTH-1:0] wb_data;
  logic [RAM_DEPTH_BITWIDTH-1:0]      victim_baddr;
  logic [RAM_DEPTH_BITWIDTH-1:0]      fill_baddr;
  logic                               fill_beat;
  logic                               fill_last;

  assign br_data_mask = '0;
  assign req_set = (LINE_IX_BITWIDTH == 0) ? '0 : SET_BITS'(req_addr >> OFFSET_BITS);
  assign req_tag = TAG_BITS'(req_addr >> (OFFSET_BITS + LINE_IX_BITWIDTH));
  assign word_ix = WORD_IX_BITS'(req_addr >> BYTE_OFF_BITS);
  assign fill_beat = (state == S_FILL) && cmd_sent && br_rd_data_valid;
  assign fill_last = fill_beat && (beat == BEAT_BITS'(RAM_BURST_DATA_COUNT - 1));
  assign fill_baddr = RAM_DEPTH_BITWIDTH'((req_addr >> OFFSET_BITS)
                      * ADDRESS_BITWIDTH'(RAM_BURST_DATA_COUNT));
  assign victim_baddr = RAM_DEPTH_BITWIDTH'(((ADDRESS_BITWIDTH'(tag_q[req_set][victim_q])
                        << LINE_IX_BITWIDTH) | ADDRESS_BITWIDTH'(req_set))
                        * ADDRESS_BITWIDTH'(RAM_BURST_DATA_COUNT));

  // Tag compare, victim choice, write merge and age update for the addressed set.
  always_comb begin
    logic [WAY_BITS-1:0] oldest_age;
    logic                found_invalid;
    logic [WAY_BITS-1:0] touch_age;
    hit           = 1'b0;
    hit_way       = '0;
    found_invalid = 1'b0;
    victim_way    = '0;
    oldest_age    = age_q[req_set][0];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    // oldest way wins unless some way is still empty; first one wins ties
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[req_set][w] > oldest_age) begin
        oldest_age = age_q[req_set][w];
        victim_way = WAY_BITS'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        found_invalid = 1'b1;
        victim_way    = WAY_BITS'(w);
      end
    end
    victim_dirty = !found_invalid && dirty_q[req_set][victim_way];
    hit_line     = line_q[req_set][hit_way];
    hit_word     = hit_line[int'(word_ix) * DATA_BITWIDTH +: DATA_BITWIDTH];
    merged_line  = hit_line;
    for (int b = 0; b < BYTES; b++) begin
      if (req_be[b]) merged_line[int'(word_ix) * DATA_BITWIDTH + b * 8 +: 8] = req_data[b * 8 +: 8];
    end
    // touched way becomes age 0; ways no older than it age by one (saturating)
    touch_way = (state == S_FILL) ? victim_q : hit_way;
    touch_age = age_q[req_set][touch_way];
    for (int w = 0; w < WAYS; w++) begin
      new_age[w] = age_q[req_set][w];
      if (WAY_BITS'(w) == touch_way) new_age[w] = '0;
      else if (age_q[req_set][w] <= touch_age && age_q[req_set][w] != '1)
        new_age[w] = age_q[req_set][w] + 1'b1;
    end
    wb_data = line_q[req_set][victim_q][int'(cmd_sent ? beat : '0) * RAM_BURST_DATA_BITWIDTH
              +: RAM_BURST_DATA_BITWIDTH];
  end

  // Line storage and per-way state; INIT sweeps the sets, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[init_set][w] <= 1'b0;
        dirty_q[init_set][w] <= 1'b0;
        age_q[init_set][w]   <= '0;
      end
    end else if (state == S_LOOKUP && hit) begin
      for (int w = 0; w < WAYS; w++) age_q[req_set][w] <= new_age[w];
      if (req_be != '0) begin
        line_q[req_set][hit_way]  <= merged_line;
        dirty_q[req_set][hit_way] <= 1'b1;
      end
    end else if (fill_beat) begin
      line_q[req_set][victim_q][int'(beat) * RAM_BURST_DATA_BITWIDTH +: RAM_BURST_DATA_BITWIDTH]
        <= br_rd_data;
      if (fill_last) begin
        tag_q[req_set][victim_q]   <= req_tag;
        valid_q[req_set][victim_q] <= 1'b1;
        dirty_q[req_set][victim_q] <= 1'b0;
        for (int w = 0; w < WAYS; w++) age_q[req_set][w] <= new_age[w];
      end
    end
  end

  // Controller FSM with registered CPU and BurstRAM outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_INIT;
      busy           <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      br_cmd         <= 1'b0;
      br_cmd_en      <= 1'b0;
      br_addr        <= '0;
      br_wr_data     <= '0;
      req_addr       <= '0;
      req_data       <= '0;
      req_be         <= '0;
      first_lookup   <= 1'b0;
      cmd_sent       <= 1'b0;
      victim_q       <= '0;
      beat           <= '0;
      init_set       <= '0;
`ifdef CACHE_STATS_EN
      stat_cache_hits   <= '0;
      stat_cache_misses <= '0;
      stat_writebacks   <= '0;
`endif
    end else begin
      data_out_valid <= 1'b0;
      br_cmd_en      <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_set == SET_BITS'(NUM_SETS - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            init_set <= init_set + 1'b1;
          end
        end
        S_IDLE: begin
          if (enable) begin
            req_addr     <= address;
            req_data     <= data_in;
            req_be       <= write_enable_bytes;
            first_lookup <= 1'b1;
            busy         <= 1'b1;
            state        <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          first_lookup <= 1'b0;
          if (hit) begin
            if (req_be == '0) begin
              data_out       <= hit_word;
              data_out_valid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            victim_q <= victim_way;
            cmd_sent <= 1'b0;
            beat     <= '0;
            state    <= victim_dirty ? S_WB : S_FILL;
          end
`ifdef CACHE_STATS_EN
          if (first_lookup) begin
            if (hit) begin
              if (stat_cache_hits != '1) stat_cache_hits <= stat_cache_hits + 1'b1;
            end else if (stat_cache_misses != '1) begin
              stat_cache_misses <= stat_cache_misses + 1'b1;
            end
          end
          if (!hit && victim_dirty && stat_writebacks != '1)
            stat_writebacks <= stat_writebacks + 1'b1;
`endif
        end
        S_WB: begin
          if (!cmd_sent) begin
            if (!br_busy) begin
              br_cmd     <= 1'b1;
              br_cmd_en  <= 1'b1;
              br_addr    <= victim_baddr;
              br_wr_data <= wb_data;
              cmd_sent   <= 1'b1;
              beat       <= BEAT_BITS'(1);
              if (RAM_BURST_DATA_COUNT == 1) begin
                cmd_sent <= 1'b0;
                beat     <= '0;
                state    <= S_FILL;
              end
            end
          end else begin
            br_wr_data <= wb_data;
            if (beat == BEAT_BITS'(RAM_BURST_DATA_COUNT - 1)) begin
              cmd_sent <= 1'b0;
              beat     <= '0;
              state    <= S_FILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (!cmd_sent) begin
            if (!br_busy) begin
              br_cmd     <= 1'b0;
              br_cmd_en  <= 1'b1;
              br_addr    <= fill_baddr;
              br_wr_data <= '0;
              cmd_sent   <= 1'b1;
              beat       <= '0;
            end
          end else if (br_rd_data_valid) begin
            if (fill_last) begin
              cmd_sent <= 1'b0;
              state    <= S_LOOKUP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: 2 ways, single set, behavioural BurstRAM.
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  write_enable_bytes = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;
  logic        br_busy;

  int n_checks = 0;
  int n_pass   = 0;

  cache_assoc #(
    .ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32), .RAM_DEPTH_BITWIDTH(4),
    .RAM_BURST_DATA_BITWIDTH(64), .RAM_BURST_DATA_COUNT(4),
    .LINE_IX_BITWIDTH(0), .WAYS_BITWIDTH(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address), .data_in(data_in),
    .write_enable_bytes(write_enable_bytes), .data_out(data_out),
    .data_out_valid(data_out_valid), .busy(busy), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  always #5 clk = ~clk;

  // BurstRAM model: 16 beats of 64 bits, lower word at the lower byte address
  logic [63:0] mem [16];
  logic        rd_active, wr_active;
  logic [1:0]  rcnt, wcnt;
  logic [3:0]  base;
  int          rd_cmds = 0, wr_cmds = 0, wr_beats = 0;
  logic [3:0]  last_rd_addr = '0, last_wr_addr = '0;

  function automatic logic [63:0] mem_init(input int i);
    case (i)
      0:       return 64'h3F5A2E14_B7C6A980;
      1:       return 64'h5D6E7F80_AB4C3E6F;
      4:       return 64'h11223344_2F5E3C7A;
      8:       return 64'h0A1B2C3D_99887766;
      default: return 64'hC0DE0000_00000000 | 64'(i);
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
      rd_active <= 1'b0; wr_active <= 1'b0; rcnt <= '0; wcnt <= '0; base <= '0;
      br_busy <= 1'b0; br_rd_data_valid <= 1'b0; br_rd_data <= '0;
    end else begin
      br_rd_data_valid <= 1'b0;
      if (wr_active) begin
        mem[base + 4'(wcnt)] <= br_wr_data;
        wr_beats <= wr_beats + 1;
        if (wcnt == 2'd3) begin wr_active <= 1'b0; br_busy <= 1'b0; end
        wcnt <= wcnt + 2'd1;
      end else if (rd_active) begin
        br_rd_data_valid <= 1'b1;
        br_rd_data <= mem[base + 4'(rcnt)];
        if (rcnt == 2'd3) begin rd_active <= 1'b0; br_busy <= 1'b0; end
        rcnt <= rcnt + 2'd1;
      end
      if (br_cmd_en) begin
        base    <= br_addr;
        br_busy <= 1'b1;
        if (br_cmd) begin
          mem[br_addr] <= br_wr_data;
          wr_beats     <= wr_beats + 1;
          wcnt         <= 2'd1;
          wr_active    <= 1'b1;
          wr_cmds      <= wr_cmds + 1;
          last_wr_addr <= br_addr;
        end else begin
          rcnt         <= 2'd0;
          rd_active    <= 1'b1;
          rd_cmds      <= rd_cmds + 1;
          last_rd_addr <= br_addr;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  // one CPU access; inputs are scrambled once accepted to prove they are latched
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_data,
                     input int exp_rd, input int exp_wr, output int lat);
    int r0, w0;
    bit done;
    wait_idle(done);
    r0 = rd_cmds; w0 = wr_cmds;
    address = a; data_in = d; write_enable_bytes = be; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; address = 32'h60; data_in = 32'hFFFF_FFFF; write_enable_bytes = 4'hF;
    lat = 0; done = 1'b0;
    while (!done && lat < 100) begin
      if ((be == 4'h0) ? data_out_valid : !busy) done = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    if (be == 4'h0) check({tag, "_data"}, 64'(data_out), 64'(exp_data));
    check({tag, "_rd_bursts"}, 64'(rd_cmds - r0), 64'(exp_rd));
    check({tag, "_wr_bursts"}, 64'(wr_cmds - w0), 64'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat, b0, nbeats, n;
    bit  ok;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_valid", 64'(data_out_valid), 64'd0);
    check("rst_cmd_en", 64'(br_cmd_en), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    rst = 1'b1;
    wait_idle(ok);
    check("init_done", 64'(ok), 64'd1);

    txn("rd0_miss", 32'd0, 32'd0, 4'h0, 32'hB7C6A980, 1, 0, lat);
    check("rd0_latency_le12", 64'(lat <= 12), 64'd1);
    txn("rd32_miss", 32'd32, 32'd0, 4'h0, 32'h2F5E3C7A, 1, 0, lat);
    txn("rd4_hit", 32'd4, 32'd0, 4'h0, 32'h3F5A2E14, 0, 0, lat);
    check("rd4_latency", 64'(lat), 64'd1);
`ifdef CACHE_STATS_EN
    check("stat_hits", 64'(dut.stat_cache_hits), 64'd1);
    check("stat_misses", 64'(dut.stat_cache_misses), 64'd2);
    check("stat_writebacks", 64'(dut.stat_writebacks), 64'd0);
`endif
    txn("rd0_hit", 32'd0, 32'd0, 4'h0, 32'hB7C6A980, 0, 0, lat);
    txn("rd68_evict32", 32'd68, 32'd0, 4'h0, 32'h0A1B2C3D, 1, 0, lat);
    check("rd68_br_addr", 64'(last_rd_addr), 64'd8);
    txn("rd8_hit", 32'd8, 32'd0, 4'h0, 32'hAB4C3E6F, 0, 0, lat);
    txn("wr0_hit", 32'd0, 32'h12345678, 4'b0010, 32'h0, 0, 0, lat);
    txn("rd0_merged", 32'd0, 32'd0, 4'h0, 32'hB7C65680, 0, 0, lat);
    txn("rd32_evict64", 32'd32, 32'd0, 4'h0, 32'h2F5E3C7A, 1, 0, lat);
    b0 = wr_beats;
    txn("rd96_evict_dirty0", 32'd96, 32'd0, 4'h0, 32'h0000000C, 1, 1, lat);
    check("wb_br_addr", 64'(last_wr_addr), 64'd0);
    check("wb_beats", 64'(wr_beats - b0), 64'd4);
    check("wb_ram_word0", 64'(mem[0][31:0]), 64'hB7C65680);
    txn("rd0_refill", 32'd0, 32'd0, 4'h0, 32'hB7C65680, 1, 0, lat);

    // reset while the third beat of a fill is on the bus
    wait_idle(ok);
    address = 32'd32; data_in = '0; write_enable_bytes = 4'h0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    nbeats = 0; n = 0;
    while (nbeats < 3 && n < 100) begin
      @(negedge clk); n++;
      if (br_rd_data_valid) nbeats++;
    end
    check("fill_beat2_reached", 64'(nbeats), 64'd3);
    rst = 1'b0;
    #1;
    check("midfill_rst_busy", 64'(busy), 64'd1);
    check("midfill_rst_data_out", 64'(data_out), 64'd0);
    check("midfill_rst_br_addr", 64'(br_addr), 64'd0);
    check("midfill_rst_cmd_en", 64'(br_cmd_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn("rd4_after_rst", 32'd4, 32'd0, 4'h0, 32'h3F5A2E14, 1, 0, lat);
    txn("wr40_alloc", 32'd40, 32'hAABBCCDD, 4'hF, 32'h0, 1, 0, lat);
    txn("rd40_hit", 32'd40, 32'd0, 4'h0, 32'hAABBCCDD, 0, 0, lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
